// File: rtl/fsm_stim_sequencer.sv
// Plays a fixed {i2,i1} table onto a pattern detector, one entry per dwell window.
// Outputs trail the state register by one clock; abort clears them on the same edge.
module fsm_stim_sequencer #(
    parameter int          NUM_STEPS = 11,
    parameter logic [31:0] PATTERN   = 32'h002E_2D2D,
    parameter int          DW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          loop_en,
    input  logic [DW-1:0] dwell,
    output logic          i2,
    output logic          i1,
    output logic          busy,
    output logic          done,
    output logic [3:0]    step_idx,
    output logic [7:0]    run_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_STEPS - 1);

    state_t        state, state_n;
    logic [DW-1:0] dwell_q, dwell_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [3:0]    step, step_n;
    logic [1:0]    pat_n;
    logic [3:0]    step_out_n;
    logic          done_n;
    logic          busy_n;
    logic [7:0]    run_cnt_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dwell_q  <= DW'(1);
            cnt      <= '0;
            step     <= '0;
            i2       <= 1'b0;
            i1       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
            run_cnt  <= '0;
        end else begin
            state    <= state_n;
            dwell_q  <= dwell_n;
            cnt      <= cnt_n;
            step     <= step_n;
            {i2, i1} <= pat_n;
            busy     <= busy_n;
            done     <= done_n;
            step_idx <= step_out_n;
            run_cnt  <= run_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        dwell_n    = dwell_q;
        cnt_n      = cnt;
        step_n     = step;
        pat_n      = 2'b00;
        step_out_n = '0;
        done_n     = 1'b0;
        run_cnt_n  = run_cnt;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    dwell_n = (dwell == '0) ? DW'(1) : dwell;
                    step_n  = '0;
                    cnt_n   = '0;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                pat_n      = PATTERN[{step, 1'b0} +: 2];
                step_out_n = step;
                if (cnt == dwell_q - 1'b1) begin
                    cnt_n = '0;
                    if (step == LAST) begin
                        state_n = FIN;
                    end else begin
                        step_n = step + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FIN: begin
                done_n = 1'b1;
                if (run_cnt != 8'hFF) begin
                    run_cnt_n = run_cnt + 8'd1;
                end
                if (loop_en) begin
                    step_n  = '0;
                    cnt_n   = '0;
                    state_n = DRIVE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort outranks completion: no pulse, no count, outputs cleared now.
        if (abort && state != IDLE) begin
            state_n    = IDLE;
            cnt_n      = '0;
            step_n     = '0;
            pat_n      = 2'b00;
            step_out_n = '0;
            done_n     = 1'b0;
            run_cnt_n  = run_cnt;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Bench for fsm_stim_sequencer: constant vector table, directed runs,
// and random traffic against a timeline model of the run.
module tb_fsm_stim_sequencer;

    localparam int          NS  = 11;
    localparam int          DW  = 16;
    localparam logic [31:0] PAT = 32'h002E_2D2D;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          loop_en;
    logic [DW-1:0] dwell;
    logic          i2, i1, busy, done;
    logic [3:0]    step_idx;
    logic [7:0]    run_cnt;

    fsm_stim_sequencer #(
        .NUM_STEPS(NS),
        .PATTERN  (PAT),
        .DW       (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .loop_en (loop_en),
        .dwell   (dwell),
        .i2      (i2),
        .i1      (i1),
        .busy    (busy),
        .done    (done),
        .step_idx(step_idx),
        .run_cnt (run_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model: a run is a timeline t = edges since the accepting edge.
    bit         m_run;
    int         m_t;
    int         m_dq;
    int         m_runs;
    logic [1:0] e_pat;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_step;
    logic [7:0] e_cnt;

    typedef struct {
        logic          s;
        logic          a;
        logic          l;
        logic [DW-1:0] d;
        logic [1:0]    ei;
        logic          eb;
        logic          ed;
        logic [3:0]    es;
        logic [7:0]    ec;
    } vec_t;

    vec_t       tbl[15];
    logic [1:0] exp_pat[11];

    task automatic check(string name, logic [1:0] ei, logic eb, logic ed,
                         logic [3:0] es, logic [7:0] ec);
        compared++;
        if ({i2, i1} !== ei || busy !== eb || done !== ed ||
            step_idx !== es || run_cnt !== ec) begin
            mismatched++;
            $display("FAIL %s @%0t: got i=%b busy=%b done=%b step=%0d run=%0d want i=%b busy=%b done=%b step=%0d run=%0d",
                     name, $time, {i2, i1}, busy, done, step_idx, run_cnt,
                     ei, eb, ed, es, ec);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_t    = 0;
        m_dq   = 1;
        m_runs = 0;
        e_pat  = 2'b00;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_step = '0;
        e_cnt  = '0;
    endtask

    task automatic model_edge();
        int k;
        e_done = 1'b0;
        if (!m_run) begin
            if (start && !abort) begin
                m_run = 1;
                m_t   = 0;
                m_dq  = (dwell == 0) ? 1 : int'(dwell);
            end
        end else if (abort) begin
            m_run = 0;
        end else begin
            m_t++;
            if (m_t == 1 + NS * m_dq) begin
                e_done = 1'b1;
                if (m_runs < 255) m_runs++;
                if (loop_en) m_t = 0;
                else m_run = 0;
            end
        end
        e_pat  = 2'b00;
        e_step = '0;
        if (m_run && m_t >= 1 && m_t <= NS * m_dq) begin
            k      = (m_t - 1) / m_dq;
            e_step = 4'(k);
            e_pat  = 2'((PAT >> (2 * k)) & 32'h3);
        end
        e_busy = m_run;
        e_cnt  = 8'(m_runs);
    endtask

    task automatic cyc(string name);
        model_edge();
        @(posedge clk);
        #1;
        check(name, e_pat, e_busy, e_done, e_step, e_cnt);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int done_edge;
        int dones;

        exp_pat = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11,
                    2'b10, 2'b00, 2'b10, 2'b11, 2'b10};
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'd0, 2'b00, 1'b1, 1'b0, 4'd0, 8'd0};
        for (int k = 0; k < NS; k++) begin
            tbl[k + 2] = '{1'b0, 1'b0, 1'b0, 16'd0, exp_pat[k],
                           1'b1, 1'b0, 4'(k), 8'd0};
        end
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'd0, 2'b00, 1'b0, 1'b1, 4'd0, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 4'd0, 8'd1};

        // T1: reset held with start asserted
        reset   = 1'b0;
        start   = 1'b1;
        abort   = 1'b0;
        loop_en = 1'b0;
        dwell   = 16'd5;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset", 2'b00, 1'b0, 1'b0, 4'd0, 8'd0);
        start = 1'b0;
        reset = 1'b1;
        cyc("post_reset");

        // T3 as constant vectors; abort also blocks a start in IDLE
        for (int v = 0; v < 15; v++) begin
            start   = tbl[v].s;
            abort   = tbl[v].a;
            loop_en = tbl[v].l;
            dwell   = tbl[v].d;
            model_edge();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", v), tbl[v].ei, tbl[v].eb,
                  tbl[v].ed, tbl[v].es, tbl[v].ec);
        end
        abort = 1'b0;

        // T2: dwell 2, done after edge 23
        dwell = 16'd2;
        start = 1'b1;
        cyc("t2_start");
        start     = 1'b0;
        done_edge = -1;
        for (int e = 1; e <= 26; e++) begin
            cyc("t2_run");
            if (done === 1'b1 && done_edge < 0) done_edge = e;
        end
        check_int("t2_done_edge", done_edge, 23);

        // T4: dwell 3, abort while step 5 is on the pins
        dwell = 16'd3;
        start = 1'b1;
        cyc("t4_start");
        start = 1'b0;
        for (int e = 1; e <= 16; e++) cyc("t4_run");
        check_int("t4_step_before_abort", int'(step_idx), 5);
        abort = 1'b1;
        cyc("t4_abort");
        abort = 1'b0;
        for (int e = 0; e < 5; e++) cyc("t4_idle");

        // T6: start with dwell 7 mid-run is ignored
        dwell = 16'd2;
        start = 1'b1;
        cyc("t6_start");
        start     = 1'b0;
        done_edge = -1;
        for (int e = 1; e <= 26; e++) begin
            if (e == 5) begin
                start = 1'b1;
                dwell = 16'd7;
            end
            cyc("t6_run");
            start = 1'b0;
            if (done === 1'b1 && done_edge < 0) done_edge = e;
        end
        check_int("t6_done_edge", done_edge, 23);

        // Async reset in the middle of a run
        dwell = 16'd3;
        start = 1'b1;
        cyc("ar_start");
        start = 1'b0;
        for (int e = 0; e < 7; e++) cyc("ar_run");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset", 2'b00, 1'b0, 1'b0, 4'd0, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("ar_after");

        // T5: loop at dwell 1, 300 runs saturate run_cnt
        loop_en = 1'b1;
        dwell   = 16'd1;
        start   = 1'b1;
        cyc("t5_start");
        start = 1'b0;
        dones = 0;
        for (int e = 1; e <= 300 * 12; e++) begin
            cyc("t5_loop");
            if (done === 1'b1) dones++;
        end
        check_int("t5_dones", dones, 300);
        check_int("t5_run_cnt", int'(run_cnt), 255);
        loop_en = 1'b0;
        for (int e = 0; e < 14; e++) cyc("t5_drain");
        check_int("t5_idle", int'(busy), 0);

        // Random traffic against the model
        reset = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int e = 0; e < 3000; e++) begin
            start   = ($urandom_range(7) == 0);
            abort   = ($urandom_range(60) == 0);
            loop_en = ($urandom_range(3) != 0);
            dwell   = 16'($urandom_range(4));
            cyc("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
